// File: rtl/cnn_pkg.sv
// cnn_pkg: shared data/address/length widths and the memory-port arbiter
// state encoding used across the CNN memory subsystem.
package cnn_pkg;

    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 16;
    localparam int LEN_SZ  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rr_select: picks one requester from a request vector, scanning upward from
// a start pointer and wrapping once. A zero pointer gives lowest-index-wins.
module rr_select
    import cnn_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand_s;
    logic             found_s;

    // Scan from ptr upward modulo NUM_REQ; the first set request wins
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr} + SUM_W'(i);
            if (cand_s >= SUM_W'(NUM_REQ)) begin
                cand_s = cand_s - SUM_W'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                found_s                        = 1'b1;
                gnt_idx                        = cand_s[IDX_W-1:0];
                gnt_onehot[cand_s[IDX_W-1:0]]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one of NUM_REQ requesters a burst on the single
// RAM port, issues one beat per cycle, returns read data one cycle after each
// beat and pulses done to the winner when the burst completes.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index
// wins, no pointer); by default arbitration is round-robin.
module mem_port_arbiter
    import cnn_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_SZ = cnn_pkg::ADDR_SZ,
    parameter int DATA_SZ = cnn_pkg::DATA_SZ,
    parameter int LEN_SZ  = cnn_pkg::LEN_SZ
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_SZ-1:0] req_addr,
    input  logic [NUM_REQ*LEN_SZ-1:0]  req_len,
    input  logic [NUM_REQ*DATA_SZ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       beat_ack,
    output logic [DATA_SZ-1:0]         rdata,
    output logic                       rdata_valid,
    output logic [NUM_REQ-1:0]         done,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_SZ-1:0]         mem_addr,
    output logic [DATA_SZ-1:0]         mem_wdata,
    input  logic [DATA_SZ-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0]     win_r, win_nxt_s;
    logic [NUM_REQ-1:0]   win_oh_r, win_oh_nxt_s;
    logic                 write_r, write_nxt_s;
    logic [ADDR_SZ-1:0]   base_r, base_nxt_s;
    logic [LEN_SZ-1:0]    len_r, len_nxt_s;
    logic [LEN_SZ-1:0]    beat_r, beat_nxt_s;
    logic [LEN_SZ-1:0]    sel_len_s;

    logic [IDX_W-1:0]     ptr_s;
    logic [NUM_REQ-1:0]   sel_onehot_s;
    logic [IDX_W-1:0]     sel_idx_s;

    logic                 issue_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r, done_r;
    logic                 mem_en_r, mem_we_r, rvalid_r;
    logic [ADDR_SZ-1:0]   mem_addr_r;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (req),
        .ptr        (ptr_s),
        .gnt_onehot (sel_onehot_s),
        .gnt_idx    (sel_idx_s)
    );

`ifdef ARB_FIXED_PRIORITY_EN
    assign ptr_s = '0;
`else
    logic [IDX_W-1:0] ptr_r;

    // Round-robin pointer: moves just past the winner as its burst finishes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (state_r == FINISH) begin
            if (win_r == IDX_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= win_r + IDX_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    assign sel_len_s = req_len[sel_idx_s*LEN_SZ +: LEN_SZ];

    // Next state and burst context; the context is only captured in IDLE so
    // later changes on the request inputs cannot disturb a running burst
    always_comb begin
        state_nxt_s  = state_r;
        win_nxt_s    = win_r;
        win_oh_nxt_s = win_oh_r;
        write_nxt_s  = write_r;
        base_nxt_s   = base_r;
        len_nxt_s    = len_r;
        beat_nxt_s   = beat_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    win_nxt_s    = sel_idx_s;
                    win_oh_nxt_s = sel_onehot_s;
                    write_nxt_s  = req_write[sel_idx_s];
                    base_nxt_s   = req_addr[sel_idx_s*ADDR_SZ +: ADDR_SZ];
                    len_nxt_s    = sel_len_s;
                    beat_nxt_s   = '0;
                    if (sel_len_s == '0) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (beat_r == len_r - LEN_SZ'(1)) begin
                    if (write_r) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    beat_nxt_s = beat_r + LEN_SZ'(1);
                end
            end
            DRAIN:   state_nxt_s = FINISH;
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign issue_nxt_s = (state_nxt_s == ISSUE);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched burst context and beat index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_r    <= '0;
            win_oh_r <= '0;
            write_r  <= 1'b0;
            base_r   <= '0;
            len_r    <= '0;
            beat_r   <= '0;
        end else begin
            win_r    <= win_nxt_s;
            win_oh_r <= win_oh_nxt_s;
            write_r  <= write_nxt_s;
            base_r   <= base_nxt_s;
            len_r    <= len_nxt_s;
            beat_r   <= beat_nxt_s;
        end
    end

    // Registered outputs describe the state being entered, so a beat's
    // strobe, address and grant all appear together in its ISSUE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_r      <= '0;
            done_r     <= '0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            rvalid_r   <= 1'b0;
        end else begin
            gnt_r      <= (state_nxt_s != IDLE) ? win_oh_nxt_s : '0;
            done_r     <= (state_nxt_s == FINISH) ? win_oh_nxt_s : '0;
            mem_en_r   <= issue_nxt_s;
            mem_we_r   <= issue_nxt_s & write_nxt_s;
            mem_addr_r <= issue_nxt_s ? (base_nxt_s + ADDR_SZ'(beat_nxt_s)) : '0;
            rvalid_r   <= mem_en_r & ~mem_we_r;
        end
    end

    // Write data follows the winner's current beat; read data is the RAM's
    // output one cycle after the read strobe. Both are zero when unqualified.
    assign mem_wdata   = mem_we_r ? req_wdata[win_r*DATA_SZ +: DATA_SZ] : '0;
    assign rdata       = rvalid_r ? mem_rdata : '0;
    assign rdata_valid = rvalid_r;
    assign beat_ack    = mem_we_r;
    assign gnt         = gnt_r;
    assign done        = done_r;
    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and randomized bursts compared
// cycle-by-cycle against a transaction-level expectation model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 11;

    logic            clk, reset;
    logic [N-1:0]    req, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic            beat_ack, rdata_valid, mem_en, mem_we;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // model state
    int            ptr_m;
    int            exp_idx;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    int            exp_len;
    logic [AW-1:0] s_addr [N];
    int            s_len  [N];
    logic          s_wr   [N];

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .beat_ack    (beat_ack),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, data equals the address read
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr;
    end

    // Winner by arbitration rule (round-robin from ptr_m, or lowest index)
    function automatic int pick(input logic [N-1:0] m);
        int p;
`ifdef ARB_FIXED_PRIORITY_EN
        p = 0;
`else
        p = ptr_m;
`endif
        for (int i = 0; i < N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Cycle (counted from the first cycle after the grant edge) of done
    function automatic int done_cyc();
        if (exp_len == 0) return 1;
        return exp_wr ? exp_len + 1 : exp_len + 2;
    endfunction

    // Expected outputs in cycle k of the current transaction
    // layout: gnt, beat_ack, rdata_valid, done, mem_en, mem_we, mem_addr, rdata, mem_wdata
    function automatic logic [59:0] model_vec(input int k);
        logic [59:0]  v;
        logic [N-1:0] oh;
        int           dk;
        v  = '0;
        oh = N'(1) << exp_idx;
        dk = done_cyc();
        if (k >= 1 && k <= dk) v[59:56] = oh;
        if (k == dk) v[53:50] = oh;
        if (exp_len > 0 && k >= 1 && k <= exp_len) begin
            v[49]    = 1'b1;
            v[47:32] = exp_addr + AW'(k - 1);
            if (exp_wr) begin
                v[55]   = 1'b1;
                v[48]   = 1'b1;
                v[15:0] = req_wdata[exp_idx*DW +: DW];
            end
        end
        if (!exp_wr && exp_len > 0 && k >= 2 && k <= exp_len + 1) begin
            v[54]    = 1'b1;
            v[31:16] = exp_addr + AW'(k - 2);
        end
        return v;
    endfunction

    function automatic logic [59:0] dut_vec(input logic keep_wd, input logic keep_rd);
        return {gnt, beat_ack, rdata_valid, done, mem_en, mem_we, mem_addr,
                (keep_rd ? rdata : 16'h0000), (keep_wd ? mem_wdata : 16'h0000)};
    endfunction

    task automatic pack_slots();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = s_addr[i];
            req_len[i*LW +: LW]  = LW'(s_len[i]);
            req_write[i]         = s_wr[i];
        end
    endtask

    // Present a request in an IDLE cycle, then drop and scramble the inputs
    task automatic start_txn(input logic [N-1:0] mask);
        @(posedge clk); #1;
        pack_slots();
        req      = mask;
        exp_idx  = pick(mask);
        exp_wr   = s_wr[exp_idx];
        exp_addr = s_addr[exp_idx];
        exp_len  = s_len[exp_idx];
`ifndef ARB_FIXED_PRIORITY_EN
        ptr_m = (exp_idx + 1) % N;
`endif
        @(posedge clk); #1;
        req       = '0;
        req_addr  = {$urandom, $urandom};
        req_len   = (N*LW)'({$urandom, $urandom});
        req_write = N'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        logic [59:0] a;
        reset = 1'b0;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            a = dut_vec(1'b1, 1'b1);
            total_cnt++;
            if (a !== 60'h0) $display("FAIL reset_state cyc %0d: got %h want 0", c, a);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        req   = '0;
        reset = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_read_burst();
        logic [59:0] e, a;
        s_addr[1] = 16'h0100; s_len[1] = 3; s_wr[1] = 1'b0;
        start_txn(4'b0010);
        for (int k = 1; k <= done_cyc() + 1; k++) begin
            @(negedge clk);
            e = model_vec(k);
            a = dut_vec(e[48], e[54]);
            total_cnt++;
            if (a !== e) $display("FAIL read_burst cyc %0d: got %h want %h", k, a, e);
            else pass_cnt++;
            @(posedge clk); #1;
            req_wdata = {$urandom, $urandom};
        end
    endtask

    task automatic test_write_wrap();
        logic [59:0] e, a;
        s_addr[2] = 16'hFFFF; s_len[2] = 2; s_wr[2] = 1'b1;
        start_txn(4'b0100);
        for (int k = 1; k <= done_cyc() + 1; k++) begin
            @(negedge clk);
            e = model_vec(k);
            a = dut_vec(e[48], e[54]);
            total_cnt++;
            if (a !== e) $display("FAIL write_wrap cyc %0d: got %h want %h", k, a, e);
            else pass_cnt++;
            @(posedge clk); #1;
            req_wdata = {$urandom, $urandom};
        end
    endtask

    task automatic test_len_zero();
        logic [59:0] e, a;
        s_addr[3] = 16'h1234; s_len[3] = 0; s_wr[3] = 1'b0;
        start_txn(4'b1000);
        for (int k = 1; k <= done_cyc() + 1; k++) begin
            @(negedge clk);
            e = model_vec(k);
            a = dut_vec(e[48], e[54]);
            total_cnt++;
            if (a !== e) $display("FAIL len_zero cyc %0d: got %h want %h", k, a, e);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        int           got [5];
        int           ng, bad, exp_g;
        logic [N-1:0] prev;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = AW'($urandom); s_len[i] = 1; s_wr[i] = 1'b1;
        end
        pack_slots();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) got[g] = -1;
        ng = 0; bad = 0; prev = '0;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) bad++;
            if (gnt != '0 && prev == '0) begin
                for (int b = 0; b < N; b++) if (gnt[b]) got[ng] = b;
                ng++;
                if (ng == 5) req = '0;
            end
            prev = gnt;
        end
        req = '0;
        total_cnt++;
        if (ng != 5) $display("FAIL contention_timeout: got %0d grants want 5", ng);
        else pass_cnt++;
        for (int g = 0; g < 5; g++) begin
            exp_g = pick(4'b1111);
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_m = (exp_g + 1) % N;
`endif
            total_cnt++;
            if (got[g] !== exp_g) $display("FAIL contention_order grant %0d: got %0d want %0d", g, got[g], exp_g);
            else pass_cnt++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL gnt_onehot: got %0d multi-bit cycles want 0", bad);
        else pass_cnt++;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [59:0] e, a;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                s_addr[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFD : AW'($urandom);
                s_len[i]  = $urandom_range(0, 5);
                s_wr[i]   = 1'($urandom);
            end
            start_txn(N'($urandom_range(1, 15)));
            for (int k = 1; k <= done_cyc() + 1; k++) begin
                @(negedge clk);
                e = model_vec(k);
                a = dut_vec(e[48], e[54]);
                total_cnt++;
                if (a !== e) $display("FAIL random it %0d cyc %0d: got %h want %h", it, k, a, e);
                else pass_cnt++;
                @(posedge clk); #1;
                req_wdata = {$urandom, $urandom};
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [59:0] e, a;
        s_addr[1] = 16'h2000; s_len[1] = 5; s_wr[1] = 1'b0;
        start_txn(4'b0010);
        @(posedge clk); #1;
        total_cnt++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h2001)
            $display("FAIL midburst_active: got en=%b addr=%h want en=1 addr=2001", mem_en, mem_addr);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        a = dut_vec(1'b1, 1'b1);
        total_cnt++;
        if (a !== 60'h0) $display("FAIL midburst_reset_async: got %h want 0", a);
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            a = dut_vec(1'b1, 1'b1);
            total_cnt++;
            if (a !== 60'h0) $display("FAIL midburst_reset_hold cyc %0d: got %h want 0", c, a);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        ptr_m = 0;
        s_addr[2] = AW'($urandom); s_len[2] = $urandom_range(1, 4); s_wr[2] = 1'($urandom);
        start_txn(4'b0100);
        for (int k = 1; k <= done_cyc() + 1; k++) begin
            @(negedge clk);
            e = model_vec(k);
            a = dut_vec(e[48], e[54]);
            total_cnt++;
            if (a !== e) $display("FAIL after_reset cyc %0d: got %h want %h", k, a, e);
            else pass_cnt++;
            @(posedge clk); #1;
            req_wdata = {$urandom, $urandom};
        end
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        ptr_m     = 0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0; s_len[i] = 0; s_wr[i] = 1'b0;
        end
        test_reset();
        test_read_burst();
        test_write_wrap();
        test_len_zero();
        test_contention();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
